// File: rtl/sample_stream_buffer.sv
// ============================================================================
// sample_stream_buffer
// ADC sample to FX3 GPIF streaming buffer: offset-binary conversion, FIFO,
// fixed-size packet bursts, short-packet flush and overflow accounting.
// Optional feature macro: SAMPLE_STREAM_TESTMODE_EN (counter test pattern).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_stream_buffer #(
    parameter int ADC_WIDTH    = 10,
    parameter int OUT_WIDTH    = 16,
    parameter int DEPTH_LOG2   = 10,
    parameter int PACKET_WORDS = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sampleValid,
    input  logic [ADC_WIDTH-1:0]  sampleData,
    input  logic                  testMode,
    input  logic                  fx3Ready,
    output logic [OUT_WIDTH-1:0]  wordData,
    output logic                  nWrite,
    output logic                  nShort,
    output logic                  nError,
    output logic [15:0]           dropCount,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int c_shift = OUT_WIDTH - ADC_WIDTH;
    localparam logic [DEPTH_LOG2:0] c_depth     = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] c_pkt       = (DEPTH_LOG2 + 1)'(PACKET_WORDS);
    localparam logic [DEPTH_LOG2:0] c_pkt_last  = (DEPTH_LOG2 + 1)'(PACKET_WORDS - 1);
    localparam logic [DEPTH_LOG2:0] c_level_one = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    logic                  w_capture;
    logic [ADC_WIDTH-1:0]  w_sample;
    logic [ADC_WIDTH-1:0]  w_adj;
    logic [OUT_WIDTH-1:0]  w_word;

    assign w_capture = enable & sampleValid;

`ifdef SAMPLE_STREAM_TESTMODE_EN
    logic [ADC_WIDTH-1:0]  r_tm_count;
    logic                  r_tm_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tm_count <= '0;
            r_tm_prev  <= 1'b0;
        end else begin
            r_tm_prev <= testMode;
            if (r_tm_prev && !testMode)
                r_tm_count <= '0;
            else if (testMode && w_capture)
                r_tm_count <= r_tm_count + 1'b1;
        end
    end

    assign w_sample = testMode ? r_tm_count : sampleData;
`else
    logic w_unused_testmode;
    assign w_unused_testmode = testMode;
    assign w_sample          = sampleData;
`endif

    // Subtracting mid-scale from offset-binary is an MSB inversion.
    assign w_adj  = {~w_sample[ADC_WIDTH-1], w_sample[ADC_WIDTH-2:0]};
    assign w_word = OUT_WIDTH'(w_adj) << c_shift;

    logic                  r_conv_valid;
    logic [OUT_WIDTH-1:0]  r_conv_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_conv_valid <= 1'b0;
            r_conv_data  <= '0;
        end else begin
            r_conv_valid <= w_capture;
            r_conv_data  <= w_word;
        end
    end

    logic [OUT_WIDTH-1:0]  r_mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [15:0]           r_drop_count;
    logic                  r_error_n;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_rd;
    logic                  w_last;

    state_t                r_state;
    state_t                r_resume;
    logic [DEPTH_LOG2:0]   r_pkt_count;
    logic                  r_flush_req;
    logic                  r_enable_d;

    // Fullness is judged on the pre-read level, so a full FIFO drops even when read.
    assign w_wr   = r_conv_valid && (r_level != c_depth);
    assign w_drop = r_conv_valid && (r_level == c_depth);

    always_comb begin
        w_rd   = 1'b0;
        w_last = 1'b0;
        if ((r_state == ST_BURST) || (r_state == ST_FLUSH))
            w_rd = fx3Ready && (r_level != '0);
        if ((r_state == ST_FLUSH) && w_rd && (r_level == c_level_one) && !w_wr)
            w_last = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_conv_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= '0;
            r_error_n    <= 1'b1;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_rd)
                r_level <= r_level + 1'b1;
            else if (!w_wr && w_rd)
                r_level <= r_level - 1'b1;
            if (w_drop) begin
                r_error_n <= 1'b0;
                if (r_drop_count != 16'hFFFF)
                    r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_resume    <= ST_BURST;
            r_pkt_count <= '0;
            r_flush_req <= 1'b0;
            r_enable_d  <= 1'b0;
            wordData    <= '0;
            nWrite      <= 1'b1;
            nShort      <= 1'b1;
        end else begin
            r_enable_d <= enable;
            nWrite     <= 1'b1;
            nShort     <= 1'b1;
            if (w_rd) begin
                wordData <= r_mem[r_rd_ptr];
                nWrite   <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable && (r_level >= c_pkt) && fx3Ready) begin
                        r_state     <= ST_BURST;
                        r_pkt_count <= '0;
                    end else if (r_flush_req) begin
                        if (r_level != '0)
                            r_state <= ST_FLUSH;
                        else
                            r_flush_req <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (!fx3Ready) begin
                        r_resume <= ST_BURST;
                        r_state  <= ST_PAUSE;
                    end else if (w_rd) begin
                        if (r_pkt_count == c_pkt_last)
                            r_state <= ST_IDLE;
                        else
                            r_pkt_count <= r_pkt_count + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (fx3Ready)
                        r_state <= r_resume;
                end
                ST_FLUSH: begin
                    if (!fx3Ready) begin
                        r_resume <= ST_FLUSH;
                        r_state  <= ST_PAUSE;
                    end else if (w_last) begin
                        nShort      <= 1'b0;
                        r_flush_req <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_level == '0) begin
                        r_flush_req <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A new falling edge of enable always re-arms the request.
            if (r_enable_d && !enable)
                r_flush_req <= 1'b1;
        end
    end

    assign level     = r_level;
    assign dropCount = r_drop_count;
    assign nError    = r_error_n;

endmodule

`default_nettype wire

// File: tb/tb_sample_stream_buffer.sv
// ============================================================================
// tb_sample_stream_buffer
// Self-checking bench: conversion table, bursts, pause, flush, overflow, reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sample_stream_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        sampleValid;
    logic [9:0]  sampleData;
    logic        testMode;
    logic        fx3Ready;
    logic [15:0] wordData;
    logic        nWrite;
    logic        nShort;
    logic        nError;
    logic [15:0] dropCount;
    logic [10:0] level;

    sample_stream_buffer #(
        .ADC_WIDTH   (10),
        .OUT_WIDTH   (16),
        .DEPTH_LOG2  (10),
        .PACKET_WORDS(256)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .sampleValid(sampleValid),
        .sampleData (sampleData),
        .testMode   (testMode),
        .fx3Ready   (fx3Ready),
        .wordData   (wordData),
        .nWrite     (nWrite),
        .nShort     (nShort),
        .nError     (nError),
        .dropCount  (dropCount),
        .level      (level)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] obs_w[$];
    logic        obs_s[$];
    int          obs_c[$];
    logic [15:0] exp_q[$];

    always @(negedge clock) begin
        cyc++;
        if (reset === 1'b0 && nWrite === 1'b0) begin
            obs_w.push_back(wordData);
            obs_s.push_back(nShort);
            obs_c.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0]  sample;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[6];

    // Reference conversion: subtract mid-scale, scale to the 16-bit top.
    function automatic logic [15:0] model_word(int s);
        int v;
        v = (s - 512) * 64;
        return 16'(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_wordData"},  32'(wordData),  32'h0);
        check({tag, "_nWrite"},    32'(nWrite),    32'h1);
        check({tag, "_nShort"},    32'(nShort),    32'h1);
        check({tag, "_nError"},    32'(nError),    32'h1);
        check({tag, "_dropCount"}, 32'(dropCount), 32'h0);
        check({tag, "_level"},     32'(level),     32'h0);
    endtask

    task automatic send(int s);
        sampleValid = 1'b1;
        sampleData  = 10'(s);
        tick();
    endtask

    task automatic send_random(int n);
        int acc = 0;
        int s;
        while (acc < n) begin
            if ($urandom_range(0, 3) != 0) begin
                s = int'($urandom_range(0, 1023));
                exp_q.push_back(model_word(s));
                send(s);
                acc++;
            end else begin
                sampleValid = 1'b0;
                tick();
            end
        end
        sampleValid = 1'b0;
    endtask

    task automatic wait_words(string name, int n, output bit ok);
        int t = 0;
        while (obs_w.size() < n && t < 5000) begin
            tick();
            t++;
        end
        ok = (obs_w.size() >= n);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, obs_w.size(), n);
        end
    endtask

    task automatic compare_words(string name, int n, int short_pos, output int gap);
        int first_c = 0;
        int last_c  = 0;
        logic [15:0] w;
        logic        s;
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            w = obs_w.pop_front();
            s = obs_s.pop_front();
            last_c = obs_c.pop_front();
            if (i == 0) first_c = last_c;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            check($sformatf("%s_word%0d", name, i), 32'(w), 32'(e));
            check($sformatf("%s_nShort%0d", name, i), 32'(s), (i == short_pos) ? 32'h0 : 32'h1);
        end
        gap = (last_c - first_c + 1) - n;
    endtask

    initial begin
        bit ok;
        int gap;
        int s;

        vecs[0] = '{10'h200, 16'h0000};
        vecs[1] = '{10'h3FF, 16'h7FC0};
        vecs[2] = '{10'h000, 16'h8000};
        vecs[3] = '{10'h201, 16'h0040};
        vecs[4] = '{10'h1FF, 16'hFFC0};
        vecs[5] = '{10'h2AB, 16'h2AC0};

        reset = 1'b1; enable = 1'b0; sampleValid = 1'b0; sampleData = '0;
        testMode = 1'b0; fx3Ready = 1'b1;
        tick(); tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Conversion table drained as one short packet.
        enable = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].word);
            send(int'(vecs[i].sample));
        end
        sampleValid = 1'b0;
        enable = 1'b0;
        tick();
        wait_words("conv", 6, ok);
        if (ok) compare_words("conv", 6, 5, gap);
        tick(); tick();
        check("conv_level", 32'(level), 32'h0);

        // Full packet with host always ready.
        enable = 1'b1;
        tick();
        send_random(256);
        wait_words("burst", 256, ok);
        if (ok) begin
            compare_words("burst", 256, -1, gap);
            check("burst_gap", 32'(gap), 32'h0);
        end
        tick(); tick(); tick();
        check("burst_level", 32'(level), 32'h0);
        check("burst_extra", 32'(obs_w.size()), 32'h0);

        // Host stalls for 5 cycles mid-packet.
        send_random(256);
        wait_words("pause_start", 50, ok);
        fx3Ready = 1'b0;
        repeat (5) tick();
        fx3Ready = 1'b1;
        wait_words("pause", 256, ok);
        if (ok) begin
            compare_words("pause", 256, -1, gap);
            check("pause_gap_ge5", 32'(gap >= 5), 32'h1);
        end
        tick(); tick(); tick();
        check("pause_extra", 32'(obs_w.size()), 32'h0);

        // 100 samples then flush.
        send_random(100);
        enable = 1'b0;
        tick();
        wait_words("flush", 100, ok);
        if (ok) compare_words("flush", 100, 99, gap);
        repeat (5) tick();
        check("flush_extra", 32'(obs_w.size()), 32'h0);
        check("flush_level", 32'(level), 32'h0);

        // Overflow: 1030 samples into 1024 entries with host stalled.
        fx3Ready = 1'b0;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 1030; i++) begin
            s = int'($urandom_range(0, 1023));
            if (i < 1024) exp_q.push_back(model_word(s));
            send(s);
        end
        sampleValid = 1'b0;
        repeat (4) tick();
        check("ovf_level", 32'(level), 32'd1024);
        check("ovf_drop", 32'(dropCount), 32'd6);
        check("ovf_nError", 32'(nError), 32'h0);
        check("ovf_nowrite", 32'(obs_w.size()), 32'h0);
        repeat (20) tick();
        check("ovf_hold_level", 32'(level), 32'd1024);
        check("ovf_hold_drop", 32'(dropCount), 32'd6);
        fx3Ready = 1'b1;
        wait_words("wrap", 1024, ok);
        if (ok) compare_words("wrap", 1024, -1, gap);
        tick(); tick();
        check("wrap_level", 32'(level), 32'h0);
        check("wrap_drop", 32'(dropCount), 32'd6);
        check("wrap_nError", 32'(nError), 32'h0);

        reset = 1'b1; enable = 1'b0; fx3Ready = 1'b0;
        tick();
        check_reset_vals("rst2");
        reset = 1'b0;
        tick();

`ifdef SAMPLE_STREAM_TESTMODE_EN
        testMode = 1'b1;
        fx3Ready = 1'b1;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(model_word(i));
            send(int'($urandom_range(0, 1023)));
        end
        sampleValid = 1'b0;
        enable = 1'b0;
        tick();
        wait_words("testmode", 5, ok);
        if (ok) compare_words("testmode", 5, 4, gap);
        testMode = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sample_stream_buffer.md
# sample_stream_buffer

Parametrised single-clock capture-to-host streaming block: accepts offset-binary ADC samples, converts them to left-justified signed words, buffers them in an internal FIFO and drains fixed-size packets to the FX3 GPIF write interface, with short-packet flush, overflow accounting and sticky error. It sits between the ADC capture stage (after clock-domain crossing) and the FX3 data/control pins. It generalises the fixed 10-bit/16-bit path in sample width, buffer depth and packet length, and adds flush and drop counting.

## Interface
- ADC_WIDTH, 10, input sample width in bits (2..OUT_WIDTH)
- OUT_WIDTH, 16, output word width in bits
- DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 words
- PACKET_WORDS, 256, words per full packet (1..2^DEPTH_LOG2)

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = capture running; falling edge requests flush
- sampleValid  in  1  sampleData valid this cycle
- sampleData  in  ADC_WIDTH  offset-binary ADC sample
- testMode  in  1  1 = replace samples with counter pattern
- fx3Ready  in  1  1 = host can accept a word this cycle
- wordData  out  OUT_WIDTH  signed output word
- nWrite  out  1  0 = wordData is written this cycle
- nShort  out  1  0 = this word ends a short packet
- nError  out  1  0 = overflow has occurred (sticky)
- dropCount  out  16  samples discarded on full, saturating
- level  out  DEPTH_LOG2+1  current FIFO occupancy

## Operation
- Conversion: word = (sampleData − 2^(ADC_WIDTH−1)) as signed, shifted left by OUT_WIDTH−ADC_WIDTH; registered, 1 cycle.
- Write: converted word enters FIFO when its valid is set and level < 2^DEPTH_LOG2. Otherwise dropped: dropCount +1 (saturating at 0xFFFF), nError cleared to 0 until reset.
- States: IDLE, BURST, PAUSE, FLUSH.
- IDLE → BURST when enable=1, level ≥ PACKET_WORDS, fx3Ready=1; packet counter cleared.
- BURST: one word per cycle with fx3Ready=1. After PACKET_WORDS words → IDLE. fx3Ready=0 → PAUSE.
- PAUSE: nWrite=1; → BURST or FLUSH, whichever was interrupted, when fx3Ready=1.
- enable 1→0 is latched as a flush request. In IDLE with request pending and level>0 → FLUSH. BURST in progress completes first.
- FLUSH: drains words until FIFO empty. Final word has nShort=0; request then cleared → IDLE.
- enable falling with FIFO empty: no output; request cleared.
- Capture is ignored while enable=0.

## Timing
- Reset values: wordData=0, nWrite=1, nShort=1, nError=1, dropCount=0, level=0, state IDLE, FIFO empty, flush request clear.
- Sample-in to FIFO write: 2 cycles (conversion register plus FIFO write). Earliest nWrite=0 is the cycle after the IDLE→BURST decision.
- wordData, nWrite and nShort are registered together. A word is consumed exactly when nWrite=0 is presented.
- Simultaneous write and read: level unchanged. Write into a full FIFO is dropped even if a read occurs in the same cycle.
- Pointers wrap modulo 2^DEPTH_LOG2.
- reset asserted mid-burst: outputs return to reset values next edge; buffered data discarded.

## Configuration
- SAMPLE_STREAM_TESTMODE_EN defined:
  - testMode=1 substitutes a 0..2^ADC_WIDTH−1 counter for sampleData on each valid cycle, wrapping.
  - The counter resets to 0 on reset or when testMode falls.
- Undefined: testMode is ignored and the counter logic is absent.

## Test plan
- Default parameters; sampleData=0x200, 0x3FF, 0x000 → wordData 0x0000, 0x7FC0, 0x8000.
- 256 samples, fx3Ready=1 → exactly 256 consecutive nWrite=0 cycles; nShort=1 throughout; level returns to 0.
- fx3Ready low for 5 cycles mid-burst → nWrite=1 for those cycles; no word lost or duplicated; 256 words total.
- 100 samples then enable=0 → 100 words in FLUSH; nShort=0 only on the 100th.
- fx3Ready=0, 1030 valid samples (DEPTH_LOG2=10) → level=1024, dropCount=6, nError=0. Held until reset, then all reset values.
- SAMPLE_STREAM_TESTMODE_EN defined, testMode=1, ADC_WIDTH=10 → words follow counter 0,1,…,1023,0 (shifted, offset-converted).
